// File: rtl/instr_bus_demux.sv
// instr_bus_demux: pipelined in-order demux from the core instruction port to NUM_SLAVES instruction memories.
module instr_bus_demux #(
  parameter int NUM_SLAVES = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = {32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = {32'hFFFF_0000, 32'hFFFF_C000}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    core_req,
  input  logic [31:0]             core_addr,
  output logic                    core_gnt,
  output logic                    core_rvalid,
  output logic [31:0]             core_rdata,
  output logic [6:0]              core_rdata_intg,
  output logic                    core_err,
  output logic [NUM_SLAVES-1:0]   slv_req,
  output logic [NUM_SLAVES*32-1:0] slv_addr,
  input  logic [NUM_SLAVES-1:0]   slv_gnt,
  input  logic [NUM_SLAVES-1:0]   slv_rvalid,
  input  logic [NUM_SLAVES*32-1:0] slv_rdata,
  input  logic [NUM_SLAVES*7-1:0] slv_rdata_intg,
  input  logic [NUM_SLAVES-1:0]   slv_err,
  output logic [2:0]              outstanding_o,
  output logic                    spurious_rvalid_o
);
  localparam int TW = $clog2(NUM_SLAVES + 1);
  localparam logic [TW-1:0] ERR = TW'(NUM_SLAVES);
  logic [2:0] cnt;
  logic [TW-1:0] cur_tgt, sel;
  logic err_pend, elig;
  logic [NUM_SLAVES-1:0] owned;
  // Descending scan so the lowest matching slave wins.
  always_comb begin
    sel = ERR;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if ((core_addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) sel = TW'(i);
  end
  // A target switch waits until every earlier transaction is answered, keeping responses in order.
  assign elig = core_req & (cnt < 3'(MAX_OUTSTANDING)) & (cnt == 3'd0 | sel == cur_tgt);
  always_comb begin
    slv_req = '0;
    slv_addr = '0;
    core_gnt = elig & (sel == ERR);
    for (int i = 0; i < NUM_SLAVES; i++)
      if (sel == TW'(i)) begin
        slv_req[i] = elig;
        slv_addr[i*32 +: 32] = core_req ? core_addr : 32'h0;
        core_gnt = elig & slv_gnt[i];
      end
  end
  always_comb begin
    owned = '0;
    core_rvalid = (cur_tgt == ERR) & err_pend;
    core_err = (cur_tgt == ERR) & err_pend;
    core_rdata = '0;
    core_rdata_intg = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (cur_tgt == TW'(i) && cnt != 3'd0) begin
        owned[i] = 1'b1;
        core_rvalid = slv_rvalid[i];
        core_rdata = slv_rdata[i*32 +: 32];
        core_rdata_intg = slv_rdata_intg[i*7 +: 7];
        core_err = slv_err[i];
      end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      cur_tgt <= '0;
      err_pend <= 1'b0;
      spurious_rvalid_o <= 1'b0;
    end else begin
      cnt <= cnt + {2'b0, core_gnt} - {2'b0, core_rvalid};
      if (core_gnt) cur_tgt <= sel;
      err_pend <= core_gnt & (sel == ERR);
      spurious_rvalid_o <= spurious_rvalid_o | (|(slv_rvalid & ~owned));
    end
  end
  assign outstanding_o = cnt;
endmodule

// File: tb/tb_instr_bus_demux.sv
// tb_instr_bus_demux: directed and random fetches checked against an in-order transaction queue model.
module tb_instr_bus_demux;
  localparam int NS = 2, MO = 2;
  localparam logic [63:0] BASE = {32'h0001_0000, 32'h0000_0000};
  localparam logic [63:0] MASK = {32'hFFFF_0000, 32'hFFFF_C000};
  logic clk = 0, rst_n = 0, core_req = 0;
  logic [31:0] core_addr = 0, core_rdata;
  logic core_gnt, core_rvalid, core_err, spurious_rvalid_o;
  logic [6:0] core_rdata_intg;
  logic [NS-1:0] slv_req, slv_gnt = 0, slv_rvalid = 0, slv_err = 0;
  logic [NS*32-1:0] slv_addr, slv_rdata = 0;
  logic [NS*7-1:0] slv_rdata_intg = 0;
  logic [2:0] outstanding_o;
  typedef struct {int tgt; int due; logic [31:0] d; logic [6:0] ig; logic e;} txn_t;
  txn_t q[$];
  int last_tgt = 0, cyc = 0, checks = 0, failures = 0;
  bit spur_exp = 0;

  instr_bus_demux #(.NUM_SLAVES(NS), .MAX_OUTSTANDING(MO), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK)) dut (
    .clk(clk), .rst_n(rst_n), .core_req(core_req), .core_addr(core_addr), .core_gnt(core_gnt),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_rdata_intg(core_rdata_intg),
    .core_err(core_err), .slv_req(slv_req), .slv_addr(slv_addr), .slv_gnt(slv_gnt),
    .slv_rvalid(slv_rvalid), .slv_rdata(slv_rdata), .slv_rdata_intg(slv_rdata_intg),
    .slv_err(slv_err), .outstanding_o(outstanding_o), .spurious_rvalid_o(spurious_rvalid_o));

  always #5 clk = ~clk;

  function automatic int dec(logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & MASK[i*32 +: 32]) == BASE[i*32 +: 32]) return i;
    return NS;
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs mid-cycle, advance the model.
  task automatic step(bit req, logic [31:0] a, logic [NS-1:0] g, int lat);
    int s;
    bit el, eg, ev;
    logic [NS-1:0] ereq;
    logic [NS*32-1:0] eaddr;
    txn_t t;
    core_req = req;
    core_addr = a;
    slv_gnt = g;
    slv_rvalid = '0;
    slv_err = '0;
    slv_rdata = {$urandom, $urandom};
    slv_rdata_intg = 14'($urandom);
    ev = q.size() > 0 && q[0].due <= cyc;
    if (ev && q[0].tgt < NS) begin
      slv_rvalid[q[0].tgt] = 1'b1;
      slv_rdata[q[0].tgt*32 +: 32] = q[0].d;
      slv_rdata_intg[q[0].tgt*7 +: 7] = q[0].ig;
      slv_err[q[0].tgt] = q[0].e;
    end
    s = dec(a);
    el = req && q.size() < MO && (q.size() == 0 || s == last_tgt);
    eg = el && (s == NS || g[s]);
    ereq = '0;
    eaddr = '0;
    if (s < NS) begin
      ereq[s] = el;
      eaddr[s*32 +: 32] = a;
    end
    @(negedge clk);
    chk("gnt", core_gnt, eg);
    chk("slv_req", slv_req, ereq);
    if (req) chk("slv_addr", slv_addr, eaddr);
    chk("rvalid", core_rvalid, ev);
    if (ev) begin
      chk("rdata", core_rdata, q[0].d);
      chk("intg", core_rdata_intg, q[0].ig);
      chk("err", core_err, q[0].e);
    end
    chk("cnt", outstanding_o, q.size());
    chk("spur", spurious_rvalid_o, spur_exp);
    if (ev) void'(q.pop_front());
    if (eg) begin
      last_tgt = s;
      t.tgt = s;
      t.due = cyc + (s == NS ? 1 : lat);
      t.d = (s == NS) ? 32'h0 : $urandom;
      t.ig = (s == NS) ? 7'h0 : 7'($urandom);
      t.e = (s == NS) ? 1'b1 : ($urandom_range(0, 7) == 0);
      q.push_back(t);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() > 0; k++) step(0, 32'h0, '0, 1);
  endtask

  initial begin
    int r;
    logic [31:0] a;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", outstanding_o, 0);
    chk("rst_spur", spurious_rvalid_o, 0);
    chk("rst_rvalid", core_rvalid, 0);
    chk("rst_gnt", core_gnt, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    // single ROM fetch, one-cycle latency
    step(1, 32'h0000_0100, 2'b01, 1);
    step(0, 32'h0, '0, 1);
    // pipelined RAM fetches with a third stalled at the outstanding limit
    step(1, 32'h0001_0000, 2'b10, 2);
    step(1, 32'h0001_0004, 2'b10, 2);
    step(1, 32'h0001_0008, 2'b10, 2);
    step(1, 32'h0001_0008, 2'b10, 2);
    drain();
    // target switch held behind a slow ROM response
    step(1, 32'h0000_0200, 2'b01, 3);
    repeat (4) step(1, 32'h0001_0010, 2'b11, 1);
    drain();
    // unmapped back-to-back plus decode boundaries
    step(1, 32'h8000_0000, 2'b11, 1);
    step(1, 32'h8000_0000, 2'b11, 1);
    step(1, 32'h0000_4000, 2'b11, 1);
    step(1, 32'h0000_3FFC, 2'b11, 1);
    drain();
    step(1, 32'h0001_FFFC, 2'b11, 1);
    drain();
    // random traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 4);
      a = (r < 2) ? ($urandom & 32'h0000_3FFC) :
          (r < 4) ? (32'h0001_0000 | ($urandom & 32'h0000_FFFC)) : (32'h8000_0000 | $urandom);
      step($urandom_range(0, 3) != 0, a, 2'($urandom), $urandom_range(1, 4));
    end
    drain();
    // spurious slave response with nothing outstanding
    core_req = 0;
    slv_gnt = '0;
    slv_rvalid = 2'b10;
    @(negedge clk);
    chk("spur_fwd", core_rvalid, 0);
    @(posedge clk);
    #1;
    cyc++;
    slv_rvalid = '0;
    spur_exp = 1;
    step(1, 32'h0000_0300, 2'b01, 1);
    step(0, 32'h0, '0, 1);
    // asynchronous reset with two requests outstanding
    step(1, 32'h0001_0020, 2'b10, 6);
    step(1, 32'h0001_0024, 2'b10, 6);
    rst_n = 0;
    core_req = 0;
    slv_gnt = '0;
    slv_rvalid = '0;
    #1;
    chk("arst_cnt", outstanding_o, 0);
    chk("arst_spur", spurious_rvalid_o, 0);
    chk("arst_rvalid", core_rvalid, 0);
    chk("arst_rdata", core_rdata, 0);
    chk("arst_err", core_err, 0);
    chk("arst_gnt", core_gnt, 0);
    chk("arst_req", slv_req, 0);
    chk("arst_addr", slv_addr, 0);
    q.delete();
    last_tgt = 0;
    spur_exp = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    step(1, 32'h0001_0000, 2'b10, 1);
    step(0, 32'h0, '0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_bus_demux.md
Name: instr_bus_demux

Overview:
- Parametrised instruction-bus demultiplexer between the Ibex instruction port and NUM_SLAVES instruction memories, e.g. boot ROM, code RAM and future XIP/cache.
- Supports up to MAX_OUTSTANDING pipelined requests, instead of one transaction at a time.
- Address decode is a parameter table.
- Unmapped addresses get an in-order error response.
- Sits in the SoC top between core_instr_bus and the memory instr buses.

Parameters:
- NUM_SLAVES, 2, number of downstream slaves (1..8).
- MAX_OUTSTANDING, 2, max granted-but-unanswered requests (1..4).
- SLAVE_BASE, {32'h0001_0000, 32'h0000_0000}, packed NUM_SLAVES*32; base of slave i at bits [32i+:32].
- SLAVE_MASK, {32'hFFFF_0000, 32'hFFFF_C000}, packed NUM_SLAVES*32; decode mask of slave i.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- core_req  in  1  core request
- core_addr  in  32  core address
- core_gnt  out  1  grant to core
- core_rvalid  out  1  response valid to core
- core_rdata  out  32  response data
- core_rdata_intg  out  7  response integrity bits
- core_err  out  1  response error
- slv_req  out  NUM_SLAVES  per-slave request
- slv_addr  out  NUM_SLAVES*32  per-slave address
- slv_gnt  in  NUM_SLAVES  per-slave grant
- slv_rvalid  in  NUM_SLAVES  per-slave response valid
- slv_rdata  in  NUM_SLAVES*32  per-slave data
- slv_rdata_intg  in  NUM_SLAVES*7  per-slave integrity bits
- slv_err  in  NUM_SLAVES  per-slave error
- outstanding_o  out  3  current outstanding count
- spurious_rvalid_o  out  1  sticky: slave rvalid seen with no request outstanding to it

Behaviour:
- Reset values: cnt=0, cur_tgt=0, err_pend=0, spurious_rvalid_o=0. All outputs are 0 while no request is active.
- Decode:
  - sel = lowest i with (core_addr & SLAVE_MASK[i]) == SLAVE_BASE[i].
  - If no slave matches, sel = ERR, a pseudo-target with index NUM_SLAVES.
- Eligibility: elig = core_req & (cnt < MAX_OUTSTANDING) & (cnt == 0 | sel == cur_tgt).
  - Switching target is only allowed once all earlier transactions have completed. This guarantees in-order responses.
- Request path, combinational:
  - If sel is a real slave: slv_req[sel] = elig and slv_addr[sel] = core_addr.
  - All other slv_req are 0 and their slv_addr are 0.
  - If elig is 0, no slave sees req.
- Grant:
  - core_gnt = elig & slv_gnt[sel] for a real slave.
  - core_gnt = elig for ERR, i.e. an immediate grant.
- On an accepted request (core_gnt=1), cur_tgt <= sel at the clock edge.
- Response path, combinational:
  - If cur_tgt is a real slave and cnt > 0: core_rvalid/rdata/rdata_intg/err = that slave's signals.
  - If cur_tgt is ERR: core_rvalid = core_err = err_pend, core_rdata = 0, core_rdata_intg = 0.
  - Otherwise all response outputs are 0.
- ERR timing: err_pend <= (core_gnt & sel == ERR). Each ERR grant is answered exactly 1 cycle later; back-to-back ERR grants give back-to-back error responses.
- Counter:
  - cnt <= cnt + core_gnt - core_rvalid.
  - A simultaneous grant and response leaves cnt unchanged.
  - cnt never exceeds MAX_OUTSTANDING and never underflows.
  - At cnt == MAX, the grant stays blocked in that cycle even if a response arrives; it is granted the following cycle.
  - outstanding_o = cnt.
- Request held against target switch: a request whose target differs from cur_tgt waits with core_gnt=0 until cnt reaches 0. The last response and a switch grant cannot occur in the same cycle, so the switch grant happens no earlier than the cycle after cnt becomes 0.
- Spurious response: slv_rvalid[i] asserted while !(cnt > 0 & cur_tgt == i) is ignored (not forwarded) and sets spurious_rvalid_o, which is cleared only by reset.
- Mid-operation reset: all state clears immediately; pending responses are lost.

Test Plan:
- Single fetch, defaults:
  - Stimulus: addr 0x0000_0100; ROM grants the same cycle and responds 1 cycle later with rdata 0xDEAD_BEEF.
  - Response: core_gnt=1 in cycle 0; core_rvalid=1 with rdata 0xDEAD_BEEF in cycle 1; cnt goes 0→1→0.
- Pipelined fetch:
  - Stimulus: RAM addrs 0x0001_0000 and 0x0001_0004 requested back-to-back; RAM grants each immediately; responses arrive 2 cycles after their grants.
  - Response: both granted in consecutive cycles; a 3rd request is stalled while cnt=2; data returned in order.
- Target switch:
  - Stimulus: ROM request outstanding (response delayed 3 cycles), then a RAM request is held.
  - Response: slv_req[1]=0 and core_gnt=0 until the cycle after the ROM rvalid; then the RAM request is granted.
- Unmapped address:
  - Stimulus: addr 0x8000_0000, twice back-to-back.
  - Response: granted immediately; core_rvalid=1, core_err=1, rdata=0 in each following cycle; no slv_req asserted.
- Spurious response:
  - Stimulus: slv_rvalid[1]=1 while cnt=0.
  - Response: core_rvalid stays 0; spurious_rvalid_o=1 and holds until rst_n is asserted.
- Reset while outstanding:
  - Stimulus: rst_n low while cnt=2.
  - Response: outstanding_o=0 and all outputs 0 immediately, without waiting for a clock edge.
